ram16_fifo_ctrl: RTL

RAM16_FIFO_CTRL -- requirements
Module: ram16_fifo_ctrl

---
 rtl/ram16_fifo_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram16_fifo_ctrl.sv
// ram16_fifo_ctrl
//   FIFO controller in front of an external 16x4 RAM with asynchronous read.
//   One registered output word (out_data/out_valid) sits after the RAM, so the
//   total capacity is 16 RAM words + 1 output word = 17 words.
//   The RAM has a single shared address, so each cycle carries at most one
//   access. A fetch (RAM -> output register) always wins over a producer write.
//
// Ports
//   clk            in   rising-edge clock for all state
//   rst            in   synchronous active-high reset
//   in_valid       in   producer offers in_data
//   in_data[3:0]   in   producer word
//   in_ready       out  controller accepts in_data this cycle
//   out_valid      out  out_data holds a valid word
//   out_data[3:0]  out  registered consumer word
//   out_ready      in   consumer takes out_data this cycle
//   ram_we         out  RAM write enable
//   ram_address    out  RAM address, shared by read and write
//   ram_write_data out  RAM write word
//   ram_read_data  in   RAM asynchronous read word at ram_address
//   level[4:0]     out  words held, 0..17
//
// Optional build macro RAM16_FIFO_ERR_EN adds two sticky error outputs:
//   ovf_err        out  producer offered a word while 17 words were held
//   udf_err        out  consumer asked for a word while the FIFO was empty
// Both are cleared only by rst. Without the macro the ports and logic are absent.

module ram16_fifo_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    input  logic       out_ready,
    output logic       ram_we,
    output logic [3:0] ram_address,
    output logic [3:0] ram_write_data,
    input  logic [3:0] ram_read_data,
    output logic [4:0] level
`ifdef RAM16_FIFO_ERR_EN
    ,
    output logic       ovf_err,
    output logic       udf_err
`endif
);

    logic [3:0] r_wr_ptr;
    logic [3:0] r_rd_ptr;
    logic [4:0] r_ram_count;
    logic       r_out_valid;
    logic [3:0] r_out_data;

    logic       w_ram_empty;
    logic       w_ram_full;
    logic       w_fetch;
    logic       w_write;

    assign w_ram_empty = (r_ram_count == 5'd0);
    assign w_ram_full  = (r_ram_count == 5'd16);

    // Refill the output register whenever the RAM has data and the register
    // is either empty or being consumed this cycle.
    assign w_fetch = !w_ram_empty && (!r_out_valid || out_ready);

    // A fetch occupies the shared RAM port, so writes are held off that cycle.
    assign in_ready = !rst && !w_ram_full && !w_fetch;
    assign w_write  = in_valid && in_ready;

    assign ram_we         = w_write;
    assign ram_address    = w_fetch ? r_rd_ptr : r_wr_ptr;
    assign ram_write_data = in_data;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign level     = r_ram_count + {4'd0, r_out_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= 4'd0;
            r_rd_ptr    <= 4'd0;
            r_ram_count <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 4'd0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 4'd1;
            end

            if (w_fetch) begin
                r_out_data  <= ram_read_data;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 4'd1;
            end else if (out_ready && r_out_valid) begin
                r_out_valid <= 1'b0;
            end

            // Write and fetch are mutually exclusive, so only one adjustment applies.
            if (w_write) begin
                r_ram_count <= r_ram_count + 5'd1;
            end else if (w_fetch) begin
                r_ram_count <= r_ram_count - 5'd1;
            end
        end
    end

`ifdef RAM16_FIFO_ERR_EN
    logic r_ovf_err;
    logic r_udf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (in_valid && (level == 5'd17)) begin
                r_ovf_err <= 1'b1;
            end
            if (out_ready && !r_out_valid && w_ram_empty) begin
                r_udf_err <= 1'b1;
            end
        end
    end

    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;
`endif

endmodule
